// File: rtl/ifu_pkg.sv
// ifu_pkg -- shared definitions for the instruction fetch unit.
//   fetch_state_e   : FSM state encoding used by inst_fetch
//   NOP_CMD         : addi x0,x0,0, the default for RESET_CMD
//   TIMEOUT_DEFAULT : default response watchdog limit in WAIT cycles
//   WDOG_W          : watchdog counter width (covers TIMEOUT up to 65535)
//   is_aligned()    : word-alignment test on a fetch address
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_CMD         = 32'h0000_0013;
  localparam int          TIMEOUT_DEFAULT = 255;
  localparam int          WDOG_W          = 16;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog -- response watchdog for the WAIT state of inst_fetch.
// Ports:
//   clk     : clock, all updates on posedge
//   rst     : synchronous active-high reset, counter to 0
//   clear   : force the counter to 0 (takes priority over enable)
//   enable  : count one cycle spent waiting
//   expired : this enabled cycle is the TIMEOUT-th one; the fetch must abort
// Parameter TIMEOUT: number of waiting cycles allowed, 1..65535.
module fetch_watchdog
  import ifu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Count value seen during the last allowed cycle; the increment at the end
  // of that cycle would make the count reach TIMEOUT.
  localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WDOG_W'(1);
    end
  end

  assign expired = enable && !clear && (count_q == LAST_CNT);

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch -- single-outstanding instruction fetch unit between the core
// PC register and an instruction memory with valid/ready request and
// valid-only response channels.
// Ports:
//   clk, rst        : clock; synchronous active-high reset
//   pc, pc_valid    : fetch request from the core (ignored while a memory
//                     access is in flight)
//   cmd, cmd_valid  : fetched instruction word; held until cmd_ready
//   cmd_ready       : core consumes cmd this cycle
//   fetch_err       : cmd is the result of a failed fetch (misaligned pc,
//                     memory fault or response timeout)
//   mem_req_*       : word-aligned read request to instruction memory
//   mem_rsp_*       : read data / access fault from instruction memory
//   busy            : unit is not IDLE
// Parameters: RESET_CMD (word driven on cmd after reset or failed fetch),
//             TIMEOUT (WAIT cycles before a fetch is aborted, 1..65535).
// Build option: define INST_FETCH_LASTPC_HIT_EN to add a one-entry
//             last-fetch buffer that answers a repeated pc without a memory
//             access. Undefined, every aligned fetch goes to memory.
module inst_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_CMD = NOP_CMD,
  parameter int          TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic [31:0] cmd,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        fetch_err,
  output logic        busy
);

  fetch_state_e state_q;
  logic [31:2]  addr_q;       // word address of the fetch in progress

  logic         accept;       // a new pc is taken this cycle
  logic         acc_misalign; // the accepted pc is not word aligned
  logic         acc_hit;      // the accepted pc is answered from the buffer
  logic         wd_clear;
  logic         wd_enable;
  logic         wd_expired;

`ifdef INST_FETCH_LASTPC_HIT_EN
  logic [31:2]  last_addr_q;
  logic [31:0]  last_cmd_q;
  logic         last_vld_q;
`endif

  // A new pc is taken from IDLE, or from HOLD in the same cycle the core
  // consumes the current cmd; in REQ and WAIT pc_valid is ignored.
  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    accept       = 1'b0;
    acc_misalign = 1'b0;
    acc_hit      = 1'b0;
    if (pc_valid && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && cmd_ready))) begin
      accept = 1'b1;
    end
    acc_misalign = !is_aligned(pc);
`ifdef INST_FETCH_LASTPC_HIT_EN
    acc_hit = last_vld_q && (pc[31:2] == last_addr_q) && !acc_misalign;
`endif
  end

  // The watchdog restarts on the request handshake and runs only in WAIT.
  assign wd_clear  = (state_q == ST_REQ) && mem_req_ready;
  assign wd_enable = (state_q == ST_WAIT);

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // The request address is the latched word address; it is stable for the
  // whole REQ state and reads 0 after reset.
  assign mem_req_addr = {addr_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      cmd           <= RESET_CMD;
      cmd_valid     <= 1'b0;
      fetch_err     <= 1'b0;
      mem_req_valid <= 1'b0;
      busy          <= 1'b0;
`ifdef INST_FETCH_LASTPC_HIT_EN
      last_vld_q    <= 1'b0;
`endif
    end else if (accept) begin
      addr_q <= pc[31:2];
      busy   <= 1'b1;
      if (acc_misalign) begin
        // Misaligned pc never reaches memory; report it as a failed fetch.
        state_q   <= ST_HOLD;
        cmd       <= RESET_CMD;
        fetch_err <= 1'b1;
        cmd_valid <= 1'b1;
`ifdef INST_FETCH_LASTPC_HIT_EN
        last_vld_q <= 1'b0;
`endif
      end else if (acc_hit) begin
`ifdef INST_FETCH_LASTPC_HIT_EN
        state_q   <= ST_HOLD;
        cmd       <= last_cmd_q;
        fetch_err <= 1'b0;
        cmd_valid <= 1'b1;
`endif
      end else begin
        state_q       <= ST_REQ;
        mem_req_valid <= 1'b1;
        cmd_valid     <= 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          busy <= 1'b0;
        end

        ST_REQ: begin
          if (mem_req_ready) begin
            state_q       <= ST_WAIT;
            mem_req_valid <= 1'b0;
          end
        end

        ST_WAIT: begin
          // A response in the timeout cycle still completes the fetch.
          if (mem_rsp_valid) begin
            state_q   <= ST_HOLD;
            cmd       <= mem_rsp_data;
            fetch_err <= mem_rsp_err;
            cmd_valid <= 1'b1;
`ifdef INST_FETCH_LASTPC_HIT_EN
            if (mem_rsp_err) begin
              last_vld_q <= 1'b0;
            end else begin
              last_vld_q  <= 1'b1;
              last_addr_q <= addr_q;
              last_cmd_q  <= mem_rsp_data;
            end
`endif
          end else if (wd_expired) begin
            state_q   <= ST_HOLD;
            cmd       <= RESET_CMD;
            fetch_err <= 1'b1;
            cmd_valid <= 1'b1;
`ifdef INST_FETCH_LASTPC_HIT_EN
            last_vld_q <= 1'b0;
`endif
          end
        end

        ST_HOLD: begin
          // cmd and fetch_err keep their values after consumption.
          if (cmd_ready) begin
            state_q   <= ST_IDLE;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef INST_FETCH_LASTPC_HIT_EN
  // NOTE: last_addr_q/last_cmd_q carry no reset; they are only read while
  // last_vld_q is set, and last_vld_q is reset.
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch -- directed self-checking bench for inst_fetch with
// TIMEOUT=4. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so each tick() advances exactly one cycle.
// Define INST_FETCH_LASTPC_HIT_EN for both bench and RTL to exercise the
// last-fetch buffer.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        fetch_err;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  inst_fetch #(
    .RESET_CMD (NOP),
    .TIMEOUT   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .cmd           (cmd),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .fetch_err     (fetch_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pc_valid pulse.
  task automatic pulse_pc(input logic [31:0] addr);
    pc       = addr;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
  endtask

  // Minimum-latency fetch through memory, checking each step.
  task automatic fetch_mem(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic err);
    pulse_pc(addr);
    check({tag, ".req_valid"}, mem_req_valid, 1);
    check({tag, ".req_addr"}, mem_req_addr, addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({tag, ".req_drop"}, mem_req_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    mem_rsp_err   = err;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    check({tag, ".cmd_valid"}, cmd_valid, 1);
    check({tag, ".cmd"}, cmd, data);
    check({tag, ".fetch_err"}, fetch_err, 32'(err));
  endtask

  task automatic consume(input string tag);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check({tag, ".consumed"}, cmd_valid, 0);
    check({tag, ".idle"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cmd"}, cmd, NOP);
    check({tag, ".cmd_valid"}, cmd_valid, 0);
    check({tag, ".req_valid"}, mem_req_valid, 0);
    check({tag, ".req_addr"}, mem_req_addr, 0);
    check({tag, ".fetch_err"}, fetch_err, 0);
    check({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of run expected $finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst           = 1'b1;
    pc            = '0;
    pc_valid      = 1'b0;
    cmd_ready     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Minimum latency: pc at T, ready at T+1, rsp at T+2, cmd_valid at T+3.
    fetch_mem("basic", 32'h8000_0000, 32'h0010_0093, 1'b0);
    check("basic.busy", busy, 1);
    consume("basic");
    check("basic.cmd_retained", cmd, 32'h0010_0093);

    // Misaligned pc: no memory request, error result next cycle.
    pulse_pc(32'h8000_0002);
    check("misalign.req_valid", mem_req_valid, 0);
    check("misalign.cmd_valid", cmd_valid, 1);
    check("misalign.cmd", cmd, NOP);
    check("misalign.fetch_err", fetch_err, 1);
    consume("misalign");

    // Request held under back-pressure; pc_valid and responses ignored in REQ.
    pulse_pc(32'h8000_0010);
    pc            = 32'h9000_0000;
    pc_valid      = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hffff_ffff;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.req_valid", mem_req_valid, 1);
      check("stall.req_addr", mem_req_addr, 32'h8000_0010);
      check("stall.cmd_valid", cmd_valid, 0);
    end
    pc_valid      = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hdead_beef;
    mem_rsp_err   = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    check("rsp_err.cmd", cmd, 32'hdead_beef);
    check("rsp_err.fetch_err", fetch_err, 1);
    check("rsp_err.cmd_valid", cmd_valid, 1);
    consume("rsp_err");

    // Timeout after 4 WAIT cycles, then a late response is ignored.
    pulse_pc(32'h8000_0020);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("timeout.waiting", cmd_valid, 0);
    end
    tick();
    check("timeout.cmd_valid", cmd_valid, 1);
    check("timeout.cmd", cmd, NOP);
    check("timeout.fetch_err", fetch_err, 1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    check("late_rsp.cmd", cmd, NOP);
    check("late_rsp.fetch_err", fetch_err, 1);
    consume("timeout");

    // Response in the last allowed WAIT cycle wins over the timeout.
    pulse_pc(32'h8000_0024);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (3) tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h00a0_0093;
    tick();
    mem_rsp_valid = 1'b0;
    check("edge_rsp.cmd", cmd, 32'h00a0_0093);
    check("edge_rsp.fetch_err", fetch_err, 0);
    consume("edge_rsp");

    // HOLD without cmd_ready: cmd stable, no new request despite pc changes.
    fetch_mem("hold", 32'h8000_0030, 32'h0030_0093, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pc       = 32'h8000_1000 + 32'(i * 4);
      pc_valid = 1'b1;
      tick();
      check("hold.cmd", cmd, 32'h0030_0093);
      check("hold.no_req", mem_req_valid, 0);
    end
    check("hold.cmd_valid", cmd_valid, 1);
    pc        = 32'h8000_0040;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    pc_valid  = 1'b0;
    check("chain.req_valid", mem_req_valid, 1);
    check("chain.req_addr", mem_req_addr, 32'h8000_0040);
    check("chain.cmd_valid", cmd_valid, 0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0040_0093;
    tick();
    mem_rsp_valid = 1'b0;
    check("chain.cmd", cmd, 32'h0040_0093);
    consume("chain");

    // Reset in WAIT abandons the fetch; the following response is dropped.
    pulse_pc(32'h8000_0050);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h5555_5555;
    tick();
    mem_rsp_valid = 1'b0;
    check_reset_outputs("mid_rst");
    tick();
    check("mid_rst.still_idle", cmd_valid, 0);

    // Repeated pc: answered from the buffer when enabled, else from memory.
    fetch_mem("first", 32'h8000_0004, 32'h0020_0093, 1'b0);
    consume("first");
`ifdef INST_FETCH_LASTPC_HIT_EN
    pulse_pc(32'h8000_0004);
    check("hit.no_req", mem_req_valid, 0);
    check("hit.cmd_valid", cmd_valid, 1);
    check("hit.cmd", cmd, 32'h0020_0093);
    check("hit.fetch_err", fetch_err, 0);
    consume("hit");
    fetch_mem("errfetch", 32'h8000_0008, 32'h0000_0bad, 1'b1);
    consume("errfetch");
    fetch_mem("refetch", 32'h8000_0004, 32'h0020_0093, 1'b0);
    consume("refetch");
`else
    fetch_mem("repeat", 32'h8000_0004, 32'h0020_0093, 1'b0);
    consume("repeat");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_CMD, 32'h0000_0013 (addi x0,x0,0): value driven on cmd after reset, misalignment or timeout.
REQ-002 Parameter TIMEOUT, 255: max cycles in WAIT before fetch abort; legal range 1..65535.
REQ-003 clk  in  1  sole clock, all state updates on posedge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 pc  in  32  fetch address from core PC register.
REQ-006 pc_valid  in  1  core requests fetch of pc.
REQ-007 cmd  out  32  fetched instruction word to core decode.
REQ-008 cmd_valid  out  1  cmd holds a complete fetch result.
REQ-009 cmd_ready  in  1  core consumes cmd this cycle.
REQ-010 mem_req_valid  out  1  instruction memory read request.
REQ-011 mem_req_addr  out  32  request address, word aligned.
REQ-012 mem_req_ready  in  1  memory accepts request.
REQ-013 mem_rsp_valid  in  1  read data returned.
REQ-014 mem_rsp_data  in  32  read data.
REQ-015 mem_rsp_err  in  1  memory reports access fault with the response.
REQ-016 fetch_err  out  1  current cmd is the result of a failed fetch; valid with cmd_valid.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, HOLD; all outputs registered.
REQ-019 IDLE: pc_valid high -> latch pc into addr_q; pc[1:0]!=0 -> HOLD with cmd=RESET_CMD, fetch_err=1, no memory request; else -> REQ.
REQ-020 REQ: mem_req_valid=1, mem_req_addr=addr_q held stable until mem_req_ready; handshake -> WAIT, watchdog cleared to 0.
REQ-021 WAIT: watchdog increments each cycle; mem_rsp_valid -> cmd=mem_rsp_data, fetch_err=mem_rsp_err, -> HOLD.
REQ-022 WAIT: watchdog reaching TIMEOUT without response -> cmd=RESET_CMD, fetch_err=1, -> HOLD; response and timeout in same cycle: response wins.
REQ-023 HOLD: cmd_valid=1, cmd/fetch_err stable until cmd_ready; cmd_ready with pc_valid -> latch new pc, apply REQ-019 checks, go REQ/HOLD directly; cmd_ready alone -> IDLE.
REQ-024 pc_valid SHALL be ignored in REQ and WAIT; mem_rsp_valid SHALL be ignored outside WAIT.
REQ-025 Minimum latency: pc_valid at cycle T, mem_req_ready at T+1, mem_rsp_valid at T+2 -> cmd_valid at T+3.
REQ-026 cmd SHALL retain its last value while cmd_valid is low.

Reset
REQ-027 rst SHALL force state IDLE, cmd=RESET_CMD, cmd_valid=0, mem_req_valid=0, mem_req_addr=0, fetch_err=0, busy=0, watchdog=0.
REQ-028 Reset mid-transaction SHALL abandon it; a late mem_rsp_valid after reset is discarded per REQ-024.

Configuration
REQ-029 Macro INST_FETCH_LASTPC_HIT_EN defined: one-entry buffer (last_addr, last_cmd, last_vld); IDLE/HOLD accept with pc==last_addr and last_vld -> HOLD next cycle with last_cmd, fetch_err=0, no memory request.
REQ-030 last_vld SHALL be set on an error-free response, cleared on rst and on any errored/timed-out fetch.
REQ-031 Macro undefined: no buffer logic; every aligned fetch goes to memory.

Structure
REQ-032 Package ifu_pkg SHALL hold the FSM state encoding, the NOP constant for RESET_CMD default and the TIMEOUT default.
REQ-033 One sub-module fetch_watchdog (clear, enable, TIMEOUT parameter, expired output) SHALL implement the WAIT counter.

Verification
REQ-034 pc=0x8000_0000 pulse, ready at T+1, rsp 0x0010_0093 at T+2 -> cmd_valid at T+3, cmd=0x0010_0093, fetch_err=0.
REQ-035 pc=0x8000_0002 -> no mem_req_valid, cmd=0x0000_0013, fetch_err=1 next cycle.
REQ-036 TIMEOUT=4, no response -> HOLD after 4 WAIT cycles, cmd=0x0000_0013, fetch_err=1; late rsp ignored.
REQ-037 cmd_ready low 5 cycles in HOLD, pc changes -> cmd stable, no new request; ready+pc_valid together -> REQ next cycle.
REQ-038 rst asserted in WAIT, rsp arrives next cycle -> outputs at reset values, cmd_valid stays 0.
REQ-039 With INST_FETCH_LASTPC_HIT_EN, fetch 0x8000_0004 twice -> second has no mem_req_valid, cmd_valid one cycle after pc_valid; after mem_rsp_err fetch, repeat goes to memory.
